// File: rtl/nibble_frame_deserializer_pkg.sv
// nibble_frame_deserializer_pkg
// Shared constants and types for the digit nibble receive path:
//   NIB_WIDTH     - BCD nibble width (fixed at 4)
//   DEF_LANES     - default number of digits per frame
//   DEF_PTR_W     - default lane pointer width for DEF_LANES
//   state_e       - deserializer FSM state encoding (LOAD / GAP)
package nibble_frame_deserializer_pkg;

  localparam int NIB_WIDTH = 4;
  localparam int DEF_LANES = 4;
  localparam int DEF_PTR_W = 2;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_frame_deserializer.sv
// nibble_frame_deserializer
// Collects NUM_LANES BCD nibbles (lane 0 first) into a shadow register and
// commits the complete frame to o_q in one step, so the display never sees a
// partially loaded time.
// Ports:
//   i_clk        - system clock, rising edge
//   i_rst_n      - asynchronous active-low reset
//   i_valid      - nibble present on i_data
//   i_data       - incoming nibble
//   i_sync       - frame restart: pointer to lane 0, partial frame dropped,
//                  overrun flag cleared
//   o_ready      - nibble accepted this cycle when i_valid is high
//   o_q          - committed frame, lane k at bits [k*NIB_W +: NIB_W]
//   o_frame_done - one-cycle pulse coincident with an o_q update
//   o_ptr        - lane the next accepted nibble will fill
//   o_overrun    - sticky: a nibble was offered while o_ready was low
module nibble_frame_deserializer
  import nibble_frame_deserializer_pkg::*;
#(
  parameter int NUM_LANES = DEF_LANES,
  parameter int NIB_W     = NIB_WIDTH,
  parameter int PTR_W     = DEF_PTR_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [NIB_W-1:0]           i_data,
  input  logic                       i_sync,
  output logic                       o_ready,
  output logic [NUM_LANES*NIB_W-1:0] o_q,
  output logic                       o_frame_done,
  output logic [PTR_W-1:0]           o_ptr,
  output logic                       o_overrun
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_LANES - 1);

  state_e                          state_r;
  state_e                          state_next_s;
  logic [PTR_W-1:0]                ptr_r;
  logic [NUM_LANES-2:0][NIB_W-1:0] shadow_s;
  logic [NUM_LANES*NIB_W-1:0]      q_r;
  logic                            frame_done_r;
  logic                            overrun_r;
  logic                            ready_s;
  logic                            accept_s;
  logic                            load_s;
  logic                            commit_s;
  logic                            drop_s;

  // i_sync outranks i_valid: a nibble offered alongside it is neither
  // accepted nor counted as an overrun.
  assign accept_s = i_valid && ready_s && !i_sync;
  assign load_s   = accept_s && (ptr_r != LAST_PTR);
  assign commit_s = accept_s && (ptr_r == LAST_PTR);
  assign drop_s   = i_valid && !ready_s && !i_sync;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: GAP always lasts exactly one cycle after a commit
  always_comb begin
    state_next_s = ST_LOAD;
    case (state_r)
      ST_LOAD: begin
        if (commit_s) begin
          state_next_s = ST_GAP;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_GAP:  state_next_s = ST_LOAD;
      default: state_next_s = ST_LOAD;
    endcase
  end

  // FSM outputs: accept nibbles only while loading
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_LOAD: ready_s = 1'b1;
      ST_GAP:  ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // Lane pointer: restarts on sync or frame completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_r <= '0;
    end else if (i_sync || commit_s) begin
      ptr_r <= '0;
    end else if (load_s) begin
      ptr_r <= ptr_r + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Shadow lanes 0..NUM_LANES-2; the last lane goes straight from i_data to
  // o_q on the commit edge, so it needs no shadow storage.
  for (genvar k = 0; k < NUM_LANES - 1; k++) begin : g_lane
    logic [NIB_W-1:0] lane_r;

    // Shadow lane k: captured when the pointer selects it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        lane_r <= '0;
      end else if (load_s && (ptr_r == PTR_W'(k))) begin
        lane_r <= i_data;
      end else begin
        lane_r <= lane_r;
      end
    end

    assign shadow_s[k] = lane_r;
  end

  // Committed frame and its completion pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_r          <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= commit_s;
      if (commit_s) begin
        q_r <= {i_data, shadow_s};
      end else begin
        q_r <= q_r;
      end
    end
  end

  // Sticky overrun flag; a sync in the same cycle clears it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overrun_r <= 1'b0;
    end else if (i_sync) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign o_ready      = ready_s;
  assign o_q          = q_r;
  assign o_frame_done = frame_done_r;
  assign o_ptr        = ptr_r;
  assign o_overrun    = overrun_r;

endmodule

// File: tb/tb_nibble_frame_deserializer.sv
// tb_nibble_frame_deserializer
// Directed bench: inputs change on the falling edge, outputs are checked on
// the following falling edge (i.e. after the intervening rising edge).
module tb_nibble_frame_deserializer;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [3:0]  data;
  logic        sync;
  logic        ready;
  logic [15:0] q;
  logic        frame_done;
  logic [1:0]  ptr;
  logic        overrun;

  int n_vec;
  int n_err;

  nibble_frame_deserializer #(
    .NUM_LANES(4),
    .NIB_W    (4),
    .PTR_W    (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_data      (data),
    .i_sync      (sync),
    .o_ready     (ready),
    .o_q         (q),
    .o_frame_done(frame_done),
    .o_ptr       (ptr),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one beat of inputs and advance to the next falling edge.
  task automatic beat(input logic v, input logic [3:0] d, input logic s);
    valid = v;
    data  = d;
    sync  = s;
    @(negedge clk);
  endtask

  // Check the frame-level outputs in one call.
  task automatic chk_all(input string tag, input logic [15:0] eq, input logic ed,
                         input logic [1:0] ep, input logic er, input logic eo);
    chk({tag, ".q"},       {16'h0, q},           {16'h0, eq});
    chk({tag, ".done"},    {31'h0, frame_done},  {31'h0, ed});
    chk({tag, ".ptr"},     {30'h0, ptr},         {30'h0, ep});
    chk({tag, ".ready"},   {31'h0, ready},       {31'h0, er});
    chk({tag, ".overrun"}, {31'h0, overrun},     {31'h0, eo});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 4'h0;
    sync  = 1'b0;

    // Reset state
    #12;
    chk_all("reset", 16'h0000, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk({"rel", ".ready"}, {31'h0, ready}, 32'h1);

    // Frame 4,3,2,1 -> 16'h1234
    beat(1'b1, 4'h4, 1'b0);
    chk("f1.ptr1", {30'h0, ptr}, 32'd1);
    beat(1'b1, 4'h3, 1'b0);
    beat(1'b1, 4'h2, 1'b0);
    chk_all("f1.pre", 16'h0000, 1'b0, 2'd3, 1'b1, 1'b0);
    beat(1'b1, 4'h1, 1'b0);
    chk_all("f1.commit", 16'h1234, 1'b1, 2'd0, 1'b0, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    chk_all("f1.after", 16'h1234, 1'b0, 2'd0, 1'b1, 1'b0);

    // Back-to-back with valid held: 1..4 commit, 5 dropped in GAP
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h2, 1'b0);
    beat(1'b1, 4'h3, 1'b0);
    beat(1'b1, 4'h4, 1'b0);
    chk_all("b2b.c1", 16'h4321, 1'b1, 2'd0, 1'b0, 1'b0);
    beat(1'b1, 4'h5, 1'b0);
    chk_all("b2b.drop", 16'h4321, 1'b0, 2'd0, 1'b1, 1'b1);
    beat(1'b1, 4'h6, 1'b0);
    beat(1'b1, 4'h7, 1'b0);
    beat(1'b1, 4'h8, 1'b0);
    chk_all("b2b.pre2", 16'h4321, 1'b0, 2'd3, 1'b1, 1'b1);
    beat(1'b1, 4'h9, 1'b0);
    chk_all("b2b.c2", 16'h9876, 1'b1, 2'd0, 1'b0, 1'b1);
    beat(1'b0, 4'h0, 1'b0);

    // Sync in LOAD with a nibble offered: clears overrun, nibble discarded
    beat(1'b1, 4'hA, 1'b0);
    chk("syn.ptr_pre", {30'h0, ptr}, 32'd1);
    beat(1'b1, 4'hB, 1'b1);
    chk_all("syn.load", 16'h9876, 1'b0, 2'd0, 1'b1, 1'b0);

    // Partial 9,8 then sync, then 1,2,3,4 -> 16'h4321
    beat(1'b1, 4'h9, 1'b0);
    beat(1'b1, 4'h8, 1'b0);
    chk("part.ptr", {30'h0, ptr}, 32'd2);
    beat(1'b0, 4'h0, 1'b1);
    chk("part.sync_ptr", {30'h0, ptr}, 32'd0);
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h2, 1'b0);
    beat(1'b1, 4'h3, 1'b0);
    chk_all("part.pre", 16'h9876, 1'b0, 2'd3, 1'b1, 1'b0);
    beat(1'b1, 4'h4, 1'b0);
    chk_all("part.commit", 16'h4321, 1'b1, 2'd0, 1'b0, 1'b0);
    // Offer in GAP sets overrun
    beat(1'b1, 4'hF, 1'b0);
    chk_all("part.ovr", 16'h4321, 1'b0, 2'd0, 1'b1, 1'b1);

    // Sync in GAP together with an offered nibble: commit stands, clear wins
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h1, 1'b0);
    beat(1'b1, 4'h1, 1'b0);
    chk_all("gsync.commit", 16'h1111, 1'b1, 2'd0, 1'b0, 1'b1);
    beat(1'b1, 4'h7, 1'b1);
    chk_all("gsync.after", 16'h1111, 1'b0, 2'd0, 1'b1, 1'b0);

    // Gapped valid: 0,5,0,5 one every 3 cycles -> 16'h5050
    beat(1'b1, 4'h0, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    chk_all("gap.l0", 16'h1111, 1'b0, 2'd1, 1'b1, 1'b0);
    beat(1'b1, 4'h5, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    chk("gap.l1.q", {16'h0, q}, 32'h1111);
    beat(1'b1, 4'h0, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    chk_all("gap.l2", 16'h1111, 1'b0, 2'd3, 1'b1, 1'b0);
    beat(1'b1, 4'h5, 1'b0);
    chk_all("gap.commit", 16'h5050, 1'b1, 2'd0, 1'b0, 1'b0);
    beat(1'b0, 4'h0, 1'b0);

    // Async reset mid-frame after 3 nibbles
    beat(1'b1, 4'h7, 1'b0);
    beat(1'b1, 4'h8, 1'b0);
    beat(1'b1, 4'h9, 1'b0);
    chk("rst.pre_ptr", {30'h0, ptr}, 32'd3);
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 16'h0000, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Values above 9 pass through: F,E,D,C -> 16'hCDEF
    beat(1'b1, 4'hF, 1'b0);
    beat(1'b1, 4'hE, 1'b0);
    beat(1'b1, 4'hD, 1'b0);
    chk("hex.pre_q", {16'h0, q}, 32'h0000);
    beat(1'b1, 4'hC, 1'b0);
    chk_all("hex.commit", 16'hCDEF, 1'b1, 2'd0, 1'b0, 1'b0);
    beat(1'b0, 4'h0, 1'b0);
    chk_all("hex.after", 16'hCDEF, 1'b0, 2'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
